// File: rtl/synth_pkg.sv
// Shared types for the synthesizer slot sequencer: note event record, sequencer
// state encoding and the index-width helper.
package synth_pkg;

    // Key field is wide enough for any supported voice count so that
    // out-of-range keys stay detectable after queueing.
    localparam int KEY_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic             note_on;
        logic [KEY_W-1:0] key_adr;
        logic [7:0]       key_val;
        logic [7:0]       vel;
    } note_event_t;

    // Bits needed to index n items; never less than 1.
    function automatic int clogb2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/synth_slot_seq_if.sv
// Note-event handshake bus between the event source and the slot sequencer.
interface synth_slot_seq_if #(
    parameter int V_WIDTH = 5
);
    logic               ev_valid;
    logic               ev_ready;
    logic               ev_note_on;
    logic [V_WIDTH-1:0] ev_key_adr;
    logic [7:0]         ev_key_val;
    logic [7:0]         ev_vel;

    modport master (
        output ev_valid, ev_note_on, ev_key_adr, ev_key_val, ev_vel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_key_adr, ev_key_val, ev_vel,
        output ev_ready
    );
endinterface

// File: rtl/synth_evq.sv
// Synchronous FIFO of note events; caller never pushes when full nor pops when empty.
module synth_evq
    import synth_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  note_event_t din_i,
    output note_event_t dout_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    note_event_t     mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/synth_slot_seq.sv
// Time-multiplex (voice, envelope) slot sequencer with a queued note-event synchroniser.
// Optional overrun reporting is built when SLOT_SEQ_OVERRUN_EN is defined.
module synth_slot_seq
    import synth_pkg::*;
#(
    parameter int VOICES    = 32,
    parameter int V_OSC     = 8,
    parameter int O_ENVS    = 2,
    parameter int V_ENVS    = V_OSC * O_ENVS,
    parameter int V_WIDTH   = clogb2(VOICES),
    parameter int E_WIDTH   = clogb2(V_ENVS),
    parameter int EVQ_DEPTH = 4
) (
    input  logic                AUDIO_CLK,
    input  logic                reset_data,
    input  logic                trig,
    synth_slot_seq_if.slave     ev,
    output logic                run,
    output logic [V_WIDTH-1:0]  slot_vx,
    output logic [E_WIDTH-1:0]  slot_env,
    output logic                osc_stb,
    output logic                frame_zero,
    output logic                frame_top,
    output logic                reg_event,
    output logic                reg_note_on,
    output logic [V_WIDTH-1:0]  reg_cur_key_adr,
    output logic [7:0]          reg_cur_key_val,
    output logic [7:0]          reg_cur_vel_on,
    output logic [VOICES-1:0]   reg_keys_on,
    output logic                frame_overrun,
    output logic [7:0]          overrun_cnt
);
    seq_state_t         state_q, state_d;
    logic [V_WIDTH-1:0] vx_q, vx_d;
    logic [E_WIDTH-1:0] env_q, env_d;
    logic               trig_q, rdy_q;
    logic               trig_edge, at_top, start;

    logic               evt_q, evt_d, on_q, on_d;
    logic [V_WIDTH-1:0] key_q, key_d;
    logic [7:0]         val_q, val_d, vel_q, vel_d;
    logic [VOICES-1:0]  keys_q, keys_d;

    logic               push, pop, key_ok, q_full, q_empty;
    note_event_t        q_din, q_head;

    assign trig_edge = trig & ~trig_q;
    assign at_top    = (state_q == SWEEP) && (vx_q == V_WIDTH'(VOICES - 1))
                       && (env_q == E_WIDTH'(V_ENVS - 1));
    // The last slot doubles as a start slot so back-to-back frames have no gap.
    assign start     = trig_edge & ((state_q == IDLE) | at_top);

    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        env_d   = env_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SWEEP;
            end
            SWEEP: begin
                if (start) begin
                    vx_d  = '0;
                    env_d = '0;
                end else if (at_top) begin
                    state_d = IDLE;
                    vx_d    = '0;
                    env_d   = '0;
                end else if (env_q == E_WIDTH'(V_ENVS - 1)) begin
                    env_d = '0;
                    vx_d  = vx_q + V_WIDTH'(1);
                end else begin
                    env_d = env_q + E_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ev.ev_ready = rdy_q & ~q_full;
    assign push        = ev.ev_valid & ev.ev_ready;
    // Empty flag is registered, so a same-cycle push is held for the next frame.
    assign pop         = start & ~q_empty;
    assign q_din       = '{note_on: ev.ev_note_on,
                           key_adr: KEY_W'(ev.ev_key_adr),
                           key_val: ev.ev_key_val,
                           vel:     ev.ev_vel};
    assign key_ok      = int'(q_head.key_adr) < VOICES;

    synth_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
        .clk     (AUDIO_CLK),
        .rst     (reset_data),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (q_din),
        .dout_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        evt_d  = evt_q;
        on_d   = on_q;
        key_d  = key_q;
        val_d  = val_q;
        vel_d  = vel_q;
        keys_d = keys_q;
        if (pop) begin
            evt_d = key_ok;
            if (key_ok) begin
                on_d   = q_head.note_on;
                key_d  = q_head.key_adr[V_WIDTH-1:0];
                val_d  = q_head.key_val;
                vel_d  = q_head.vel;
                keys_d[q_head.key_adr[V_WIDTH-1:0]] = q_head.note_on;
            end
        end else if (start | at_top) begin
            evt_d = 1'b0;
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            state_q <= IDLE;
            vx_q    <= '0;
            env_q   <= '0;
            trig_q  <= 1'b0;
            rdy_q   <= 1'b0;
            evt_q   <= 1'b0;
            on_q    <= 1'b0;
            key_q   <= '0;
            val_q   <= '0;
            vel_q   <= '0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            env_q   <= env_d;
            trig_q  <= trig;
            rdy_q   <= 1'b1;
            evt_q   <= evt_d;
            on_q    <= on_d;
            key_q   <= key_d;
            val_q   <= val_d;
            vel_q   <= vel_d;
            keys_q  <= keys_d;
        end
    end

    assign run             = (state_q == SWEEP);
    assign slot_vx         = vx_q;
    assign slot_env        = env_q;
    assign osc_stb         = run && (int'(env_q) % O_ENVS == 0);
    assign frame_zero      = run && (vx_q == '0) && (env_q == '0);
    assign frame_top       = at_top;
    assign reg_event       = evt_q;
    assign reg_note_on     = on_q;
    assign reg_cur_key_adr = key_q;
    assign reg_cur_key_val = val_q;
    assign reg_cur_vel_on  = vel_q;
    assign reg_keys_on     = keys_q;

`ifdef SLOT_SEQ_OVERRUN_EN
    logic       reject, ovr_q;
    logic [7:0] ovr_cnt_q;

    assign reject = trig_edge & (state_q == SWEEP) & ~at_top;

    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            ovr_q <= reject;
            if (reject && (ovr_cnt_q != 8'hFF)) ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign frame_overrun = ovr_q;
    assign overrun_cnt   = ovr_cnt_q;
`else
    assign frame_overrun = 1'b0;
    assign overrun_cnt   = '0;
`endif
endmodule

// File: tb/tb_synth_slot_seq.sv
// Randomised and directed bench for synth_slot_seq against a slot-counter/queue model.
module tb_synth_slot_seq;
    localparam int VOICES = 3;
    localparam int V_OSC  = 2;
    localparam int O_ENVS = 2;
    localparam int V_ENVS = V_OSC * O_ENVS;
    localparam int N      = VOICES * V_ENVS;
    localparam int DEPTH  = 4;
`ifdef SLOT_SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, trig;
    logic run, osc_stb, frame_zero, frame_top, reg_event, reg_note_on, frame_overrun;
    logic [1:0] slot_vx, slot_env, reg_cur_key_adr;
    logic [7:0] reg_cur_key_val, reg_cur_vel_on, overrun_cnt;
    logic [VOICES-1:0] reg_keys_on;

    synth_slot_seq_if #(.V_WIDTH(2)) evif ();

    synth_slot_seq #(.VOICES(VOICES), .V_OSC(V_OSC), .O_ENVS(O_ENVS), .EVQ_DEPTH(DEPTH)) dut (
        .AUDIO_CLK(clk), .reset_data(rst), .trig(trig), .ev(evif),
        .run(run), .slot_vx(slot_vx), .slot_env(slot_env), .osc_stb(osc_stb),
        .frame_zero(frame_zero), .frame_top(frame_top), .reg_event(reg_event),
        .reg_note_on(reg_note_on), .reg_cur_key_adr(reg_cur_key_adr),
        .reg_cur_key_val(reg_cur_key_val), .reg_cur_vel_on(reg_cur_vel_on),
        .reg_keys_on(reg_keys_on), .frame_overrun(frame_overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit on; int key; int val; int vel; } mev_t;
    mev_t m_q[$];
    bit   m_active, m_trig_prev, m_rdy, m_evt, m_on, m_ovr;
    int   m_slot, m_key, m_val, m_vel, m_ovr_cnt;
    bit [VOICES-1:0] m_keys;
    bit   md_edge, md_last, md_start, md_push;
    mev_t md_h;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_active = 0; m_slot = 0; m_trig_prev = 0; m_rdy = 0;
            m_evt = 0; m_on = 0; m_key = 0; m_val = 0; m_vel = 0; m_keys = '0;
            m_ovr = 0; m_ovr_cnt = 0;
        end else begin
            md_edge  = trig && !m_trig_prev;
            md_last  = m_active && (m_slot == N - 1);
            md_start = md_edge && (!m_active || md_last);
            md_push  = evif.ev_valid && m_rdy && (m_q.size() < DEPTH);
            m_ovr    = md_edge && m_active && !md_last;
            if (m_ovr && m_ovr_cnt < 255) m_ovr_cnt++;
            if (md_start) begin
                m_evt = 0;
                if (m_q.size() > 0) begin
                    md_h = m_q.pop_front();
                    if (md_h.key < VOICES) begin
                        m_evt = 1; m_on = md_h.on; m_key = md_h.key;
                        m_val = md_h.val; m_vel = md_h.vel;
                        m_keys[md_h.key] = md_h.on;
                    end
                end
                m_active = 1; m_slot = 0;
            end else if (md_last) begin
                m_active = 0; m_slot = 0; m_evt = 0;
            end else if (m_active) begin
                m_slot++;
            end
            if (md_push) m_q.push_back('{on: evif.ev_note_on, key: int'(evif.ev_key_adr),
                                         val: int'(evif.ev_key_val), vel: int'(evif.ev_vel)});
            m_trig_prev = trig;
            m_rdy = 1;
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("run", 32'(run), 32'(m_active));
            chk("slot_vx", 32'(slot_vx), m_active ? 32'(m_slot / V_ENVS) : 32'd0);
            chk("slot_env", 32'(slot_env), m_active ? 32'(m_slot % V_ENVS) : 32'd0);
            chk("osc_stb", 32'(osc_stb), 32'(m_active && ((m_slot % V_ENVS) % O_ENVS == 0)));
            chk("frame_zero", 32'(frame_zero), 32'(m_active && m_slot == 0));
            chk("frame_top", 32'(frame_top), 32'(m_active && m_slot == N - 1));
            chk("ev_ready", 32'(evif.ev_ready), 32'(m_rdy && m_q.size() < DEPTH));
            chk("reg_event", 32'(reg_event), 32'(m_evt));
            chk("reg_note_on", 32'(reg_note_on), 32'(m_on));
            chk("reg_key_adr", 32'(reg_cur_key_adr), 32'(m_key));
            chk("reg_key_val", 32'(reg_cur_key_val), 32'(m_val));
            chk("reg_vel", 32'(reg_cur_vel_on), 32'(m_vel));
            chk("reg_keys_on", 32'(reg_keys_on), 32'(m_keys));
            chk("frame_overrun", 32'(frame_overrun), OVR_EN ? 32'(m_ovr) : 32'd0);
            chk("overrun_cnt", 32'(overrun_cnt), OVR_EN ? 32'(m_ovr_cnt) : 32'd0);
        end
    end

    // ---------------- directed observation helpers ----------------
    int s_run, s_top, s_zero, s_osc, s_maxvx, s_maxenv, s_fall, s_ovr, s_evt, s_val;
    bit s_prev_run;

    task automatic clr_stats();
        s_run = 0; s_top = 0; s_zero = 0; s_osc = 0; s_maxvx = 0; s_maxenv = 0;
        s_fall = 0; s_ovr = 0; s_evt = 0; s_val = -1; s_prev_run = 0;
    endtask

    // Sample n cycles; trig is dropped each cycle, optionally re-raised on frame_top once.
    task automatic observe(input int n, input bit b2b);
        bit armed;
        armed = b2b;
        repeat (n) begin
            @(negedge clk);
            if (run) begin
                s_run++;
                if (int'(slot_vx) > s_maxvx) s_maxvx = int'(slot_vx);
                if (int'(slot_env) > s_maxenv) s_maxenv = int'(slot_env);
                if (reg_event) s_evt++;
                s_val = int'(reg_cur_key_val);
            end
            if (s_prev_run && !run) s_fall++;
            s_prev_run = run;
            s_top  += int'(frame_top);
            s_zero += int'(frame_zero);
            s_osc  += int'(osc_stb);
            s_ovr  += int'(frame_overrun);
            trig = 1'b0;
            if (armed && frame_top) begin
                trig = 1'b1;
                armed = 0;
            end
        end
    endtask

    task automatic push_ev(input bit on, input logic [1:0] key, input logic [7:0] val, input logic [7:0] vel);
        @(negedge clk);
        evif.ev_valid = 1'b1; evif.ev_note_on = on; evif.ev_key_adr = key;
        evif.ev_key_val = val; evif.ev_vel = vel;
    endtask

    task automatic stop_push();
        @(negedge clk);
        evif.ev_valid = 1'b0;
    endtask

    task automatic frame();
        clr_stats();
        @(negedge clk);
        trig = 1'b1;
        observe(N + 2, 1'b0);
    endtask

    initial begin
        bit found;
        rst = 1'b1; trig = 1'b0;
        evif.ev_valid = 1'b0; evif.ev_note_on = 1'b0; evif.ev_key_adr = '0;
        evif.ev_key_val = '0; evif.ev_vel = '0;
        @(posedge clk);
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("lit_reset_run", 32'(run), 32'd0);
        chk("lit_reset_ready", 32'(evif.ev_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_ready_after_reset", 32'(evif.ev_ready), 32'd1);

        // single frame
        frame();
        chk("lit_run_cycles", 32'(s_run), 32'd12);
        chk("lit_top_cnt", 32'(s_top), 32'd1);
        chk("lit_zero_cnt", 32'(s_zero), 32'd1);
        chk("lit_osc_cnt", 32'(s_osc), 32'd6);
        chk("lit_max_vx", 32'(s_maxvx), 32'd2);
        chk("lit_max_env", 32'(s_maxenv), 32'd3);

        // back-to-back frames
        clr_stats();
        @(negedge clk);
        trig = 1'b1;
        observe(2 * N + 4, 1'b1);
        chk("lit_b2b_run", 32'(s_run), 32'd24);
        chk("lit_b2b_falls", 32'(s_fall), 32'd1);
        chk("lit_b2b_zero", 32'(s_zero), 32'd2);

        // edge in the middle of a sweep
        clr_stats();
        @(negedge clk);
        trig = 1'b1;
        observe(5, 1'b0);
        trig = 1'b1;
        observe(N, 1'b0);
        chk("lit_ovr_run", 32'(s_run), 32'd12);
        chk("lit_ovr_falls", 32'(s_fall), 32'd1);
        chk("lit_ovr_pulses", 32'(s_ovr), OVR_EN ? 32'd1 : 32'd0);
        chk("lit_ovr_cnt", 32'(overrun_cnt), OVR_EN ? 32'd1 : 32'd0);

        // fill queue past depth, then drain one event per frame
        for (int i = 0; i < 5; i++) push_ev(1'b1, 2'(i % 3), 8'(10 + i), 8'(20 + i));
        stop_push();
        chk("lit_full_ready", 32'(evif.ev_ready), 32'd0);
        for (int f = 0; f < 5; f++) begin
            frame();
            chk("lit_drain_evt", 32'(s_evt), (f < 4) ? 32'd12 : 32'd0);
            if (f < 4) chk("lit_drain_val", 32'(s_val), 32'(10 + f));
        end

        // reset in the middle of a sweep with events queued
        for (int i = 0; i < 3; i++) push_ev(1'b1, 2'(i), 8'(40 + i), 8'(50 + i));
        stop_push();
        @(negedge clk);
        trig = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            trig = 1'b0;
            if (run && slot_vx == 2'd1 && slot_env == 2'd2) found = 1;
        end
        chk("lit_found_slot_1_2", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("lit_rst_run", 32'(run), 32'd0);
        chk("lit_rst_keys", 32'(reg_keys_on), 32'd0);
        chk("lit_rst_evt", 32'(reg_event), 32'd0);
        @(negedge clk);
        chk("lit_rst_ready", 32'(evif.ev_ready), 32'd1);
        frame();
        chk("lit_rst_no_event", 32'(s_evt), 32'd0);

        // key bitmap: on key 2, off key 2, out-of-range key 3
        push_ev(1'b1, 2'd2, 8'h55, 8'h66);
        stop_push();
        frame();
        chk("lit_keys_on_2", 32'(reg_keys_on), 32'b100);
        push_ev(1'b0, 2'd2, 8'h57, 8'h68);
        stop_push();
        frame();
        chk("lit_keys_off_2", 32'(reg_keys_on), 32'b000);
        chk("lit_off_evt", 32'(s_evt), 32'd12);
        push_ev(1'b1, 2'd3, 8'h77, 8'h88);
        stop_push();
        frame();
        chk("lit_bad_key_evt", 32'(s_evt), 32'd0);
        chk("lit_bad_key_keys", 32'(reg_keys_on), 32'b000);
        chk("lit_bad_key_hold", 32'(reg_cur_key_adr), 32'd2);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            trig = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            evif.ev_valid   = ($urandom_range(0, 2) == 0);
            evif.ev_note_on = 1'($urandom_range(0, 1));
            evif.ev_key_adr = 2'($urandom_range(0, 3));
            evif.ev_key_val = 8'($urandom_range(0, 255));
            evif.ev_vel     = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        trig = 1'b0; rst = 1'b0; evif.ev_valid = 1'b0;
        repeat (2 * N) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
